seg7_multi_display: RTL

Parametrised multi-digit 7-segment display driver for the DE1-SoC common-anode (active-low) displays. It accepts a binary value with a load strobe. In decimal mode it converts the value to BCD with a sequential shift-add-3 (double-dabble) engine; in hex mode it takes the nibbles directly. It also provides leading-zero blanking, overflow indication and a blink mode. It sits between the CPU I/O port registers and the HEX0..HEXn pins, and supersedes the single-digit decoder.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_encode.sv | 33 +++
 rtl/seg7_multi_display.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multi-digit 7-segment driver.
// Segment patterns are active-low, bit 6 = g ... bit 0 = a.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // 0..15 select a nibble glyph; the two codes above that are special glyphs.
    typedef logic [4:0] digit_code_t;

    localparam digit_code_t CODE_BLANK = 5'd16;
    localparam digit_code_t CODE_MINUS = 5'd17;

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-code to active-low segment pattern decoder.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            5'd0:       seg = SEG_0;
            5'd1:       seg = SEG_1;
            5'd2:       seg = SEG_2;
            5'd3:       seg = SEG_3;
            5'd4:       seg = SEG_4;
            5'd5:       seg = SEG_5;
            5'd6:       seg = SEG_6;
            5'd7:       seg = SEG_7;
            5'd8:       seg = SEG_8;
            5'd9:       seg = SEG_9;
            5'd10:      seg = SEG_A;
            5'd11:      seg = SEG_B;
            5'd12:      seg = SEG_C;
            5'd13:      seg = SEG_D;
            5'd14:      seg = SEG_E;
            5'd15:      seg = SEG_F;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_multi_display.sv
// Multi-digit 7-segment driver: sequential double-dabble for decimal, direct nibbles for hex,
// with leading-zero blanking, overflow dashes and a free-running blink.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [DATA_W-1:0]       value,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    ready,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam int EXT_W   = BCD_W + DATA_W;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   val_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                sticky_q;
    logic                blz_q;
    logic                ovf_q;
    digit_code_t         disp_q  [NUM_DIGITS];
    digit_code_t         codes_d [NUM_DIGITS];
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic                blink_phase_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_shift;
    logic                shift_out;
    logic [EXT_W-1:0]    value_ext;
    logic                hex_ovf;
    logic                start;
    logic                last_shift;
    logic                disp_we;
    logic [BCD_W-1:0]    src;
    logic                ovf_new;
    logic                blz_sel;
    logic                seen;
    logic [3:0]          nib;

    assign start      = (state_q == IDLE) && load;
    assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
    assign disp_we    = (start && hex_mode) || last_shift;

    assign busy     = (state_q != IDLE);
    assign ready    = (state_q == DONE);
    assign overflow = ovf_q;

    // Zero-extension makes nibbles beyond DATA_W read as 0 and isolates the overflow bits.
    assign value_ext = {{BCD_W{1'b0}}, value};
    assign hex_ovf   = |value_ext[EXT_W-1:BCD_W];

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shift_out = bcd_adj[BCD_W-1];
        bcd_shift = {bcd_adj[BCD_W-2:0], val_q[DATA_W-1]};
    end

    // Display codes are built from whichever result is landing this edge.
    always_comb begin
        if (state_q == IDLE) begin
            src     = value_ext[BCD_W-1:0];
            ovf_new = hex_ovf;
            blz_sel = blank_lz;
        end else begin
            src     = bcd_shift;
            ovf_new = sticky_q | shift_out;
            blz_sel = blz_q;
        end
        seen = 1'b0;
        nib  = 4'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = src[4*i +: 4];
            if (nib != 4'd0 || i == 0) begin
                seen = 1'b1;
            end
            if (ovf_new) begin
                codes_d[i] = CODE_MINUS;
            end else if (blz_sel && !seen) begin
                codes_d[i] = CODE_BLANK;
            end else begin
                codes_d[i] = {1'b0, nib};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = hex_mode ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            val_q    <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            blz_q    <= 1'b0;
            ovf_q    <= 1'b0;
            disp_q   <= '{default: '0};
        end else begin
            if (start) begin
                val_q    <= value;
                blz_q    <= blank_lz;
                bcd_q    <= '0;
                sticky_q <= 1'b0;
                cnt_q    <= CNT_W'(DATA_W);
            end else if (state_q == SHIFT) begin
                val_q    <= val_q << 1;
                bcd_q    <= bcd_shift;
                sticky_q <= sticky_q | shift_out;
                cnt_q    <= cnt_q - CNT_W'(1);
            end
            if (disp_we) begin
                disp_q <= codes_d;
                ovf_q  <= ovf_new;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [6:0] seg;

        seg7_encode u_encode (
            .code (disp_q[g]),
            .seg  (seg)
        );

        assign hex_out[7*g +: 7] = (blink_en && blink_phase_q) ? 7'h7f : seg;
    end

endmodule
